float_div_seq: RTL
==================

# float_div_seq

Sequential IEEE-754 single-precision divider. It computes floatA / floatB with a restoring mantissa divider, one quotient bit per clock, behind a start/done handshake. It is the inverse-direction companion to the combinational `floatMult` in the CNN arithmetic datapath, and is used for normalisation and averaging steps where a per-cycle result is not needed. Arithmetic conventions match `floatMult`: subnormals are flushed to zero and rounding is toward zero (truncate).

## Interface
Parameters: none.

Ports (clock and reset first):
- `clk` input 1 — single clock; all state changes on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — request; sampled only in IDLE.
- `floatA` input 32 — dividend; captured on the accepted `start`.
- `floatB` input 32 — divisor; captured on the accepted `start`.
- `busy` output 1 — high from the cycle after an accepted `start` until `done`, inclusive.
- `done` output 1 — one-cycle pulse; `quotient` and `div_by_zero` are valid from this cycle.
- `quotient` output 32 — result; held until the next `done`.
- `div_by_zero` output 1 — set with `done` when the divisor is zero; held like `quotient`.

## Operation
- Reset (asynchronous, `rst_n`=0):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `quotient`=0x00000000, `div_by_zero`=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the division; no `done` is produced.
- States:
  - IDLE: on `start`=1, capture operands and go to DIVIDE.
  - DIVIDE: lasts 25 cycles; the counter counts 24 down to 0.
  - NORM: lasts 1 cycle.
  - DONE: lasts 1 cycle; `done`=1. Then go to IDLE.
- `start` is ignored outside IDLE. In DONE, a `start` is not accepted; it is first sampled on the following IDLE cycle.
- Decode on capture:
  - sign = A[31] ^ B[31].
  - An exponent field of 0 means zero (the mantissa is ignored).
  - An exponent field of 255 means Inf/NaN.
  - Mantissas are extended with the hidden 1 to 24 bits: mA, mB.
- Exponent: e = eA − eB + 127, computed as a 10-bit signed value.
- Divide: restoring division producing 25 bits, q = floor(mA·2^24 / mB).
  - The remainder register is 25 bits wide.
  - Each DIVIDE cycle: shift, trial-subtract mB, set the q bit if the result is non-negative, otherwise restore.
- Normalise (in NORM):
  - If q[24]=1: mantissa = q[23:1], exponent = e.
  - Otherwise: mantissa = q[22:0], exponent = e−1.
  - Remainder bits are discarded (truncation).
- Results, in priority order (the highest match wins):
  1. Either input exponent is 255 → `quotient`=0x7FC00000. `div_by_zero`=1 only if B is zero.
  2. A zero and B zero → 0x7FC00000, `div_by_zero`=1.
  3. B zero → {sign, 0xFF, 23'b0}, `div_by_zero`=1.
  4. A zero → {sign, 31'b0}.
  5. Final exponent ≤ 0 → {sign, 31'b0} (underflow, flushed to zero).
  6. Final exponent ≥ 255 → {sign, 0xFF, 23'b0} (overflow).
  7. Otherwise → {sign, exponent[7:0], mantissa}.
- Special cases still traverse DIVIDE and NORM, so latency is fixed.

## Timing
- Let cycle 0 be the rising edge at which `start`=1 is sampled in IDLE.
- Cycles 1–25: DIVIDE, `busy`=1.
- Cycle 26: NORM, `busy`=1.
- Cycle 27: DONE. `done`=1, `busy`=1. `quotient` and `div_by_zero` are updated on this edge.
- Cycle 28: IDLE, `busy`=0, `done`=0. A new `start` is accepted here at the earliest.
- Latency is a fixed 27 cycles, start edge to `done`. Throughput is one operation per 28 cycles.
- Operand inputs may change freely after cycle 0.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- 0x3F800000 / 0x40000000 (1/2) → `quotient`=0x3F000000, `div_by_zero`=0, `done` exactly 27 cycles after `start`. 0xBFC00000 / 0x3F000000 (−1.5/0.5) → 0xC0400000.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA, confirming truncation. 0x40C00000 / 0x40400000 (6/3) → 0x40000000.
- 0x40000000 / 0x00000000 → 0x7F800000, `div_by_zero`=1. 0x00000000 / 0x00000000 → 0x7FC00000, `div_by_zero`=1. 0x00000000 / 0x40000000 → 0x00000000, `div_by_zero`=0.
- Range limits:
  - Underflow: 0x00800000 / 0x40000000 → 0x00000000.
  - Overflow: 0x7F000000 / 0x3F000000 → 0x7F800000.
  - Inf input: 0x7F800000 / 0x3F800000 → 0x7FC00000.
- Handshake:
  - Pulse `start` on cycles 5 and 20 after the first accept → both ignored; exactly one `done` is produced.
  - Hold `start` high continuously → accepts at cycles 0, 28, 56, ….
  - `quotient` holds its value between `done` pulses.
- Reset: assert `rst_n`=0 at cycle 10 of a division → all outputs are 0 immediately (asynchronous), no `done` follows, and the next `start` completes normally.

Source files
------------

// File: rtl/float_div_seq.sv
// Sequential IEEE-754 single-precision divider (floatA / floatB).
// Restoring mantissa division, one quotient bit per clock, fixed 27-cycle
// latency from accepted start to done. Subnormals flush to zero and the
// result is truncated (round toward zero), matching floatMult.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands captured and decoded on accept
// DIVIDE | 25 restoring-division steps, counter runs 24 down to 0
// NORM   | normalise quotient, resolve special cases, raise done
// DONE   | done pulse visible for one cycle, then back to IDLE
module float_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] floatA,
  input  logic [31:0] floatB,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [24:0]        rem;
  logic [24:0]        q;
  logic [23:0]        mb;
  logic signed [9:0]  e;
  logic               sign;
  logic               a_zero;
  logic               b_zero;
  logic               a_spec;
  logic               b_spec;

  logic [25:0]        diff;
  logic signed [9:0]  exp_n;
  logic [22:0]        mant_n;
  logic [31:0]        res_q;
  logic               res_dbz;

  // Trial subtraction; bit 25 set means the remainder is smaller than mB.
  assign diff = {1'b0, rem} - {2'b00, mb};

  // Normalisation and special-case priority, consumed in NORM.
  always_comb begin
    exp_n   = q[24] ? e : e - 10'sd1;
    mant_n  = q[24] ? q[23:1] : q[22:0];
    res_q   = {sign, exp_n[7:0], mant_n};
    res_dbz = 1'b0;
    if (a_spec || b_spec) begin
      res_q   = 32'h7FC0_0000;
      res_dbz = b_zero;
    end else if (a_zero && b_zero) begin
      res_q   = 32'h7FC0_0000;
      res_dbz = 1'b1;
    end else if (b_zero) begin
      res_q   = {sign, 8'hFF, 23'd0};
      res_dbz = 1'b1;
    end else if (a_zero) begin
      res_q   = {sign, 31'd0};
    end else if (exp_n <= 10'sd0) begin
      res_q   = {sign, 31'd0};
    end else if (exp_n >= 10'sd255) begin
      res_q   = {sign, 8'hFF, 23'd0};
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      rem         <= 25'd0;
      q           <= 25'd0;
      mb          <= 24'd0;
      e           <= 10'sd0;
      sign        <= 1'b0;
      a_zero      <= 1'b0;
      b_zero      <= 1'b0;
      a_spec      <= 1'b0;
      b_spec      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // The hidden 1 is always inserted, so the mantissa divider never
            // sees a zero divisor; zero operands are handled by the flags.
            rem    <= {2'b01, floatA[22:0]};
            mb     <= {1'b1, floatB[22:0]};
            q      <= 25'd0;
            e      <= $signed({2'b00, floatA[30:23]})
                    - $signed({2'b00, floatB[30:23]}) + 10'sd127;
            sign   <= floatA[31] ^ floatB[31];
            a_zero <= (floatA[30:23] == 8'd0);
            b_zero <= (floatB[30:23] == 8'd0);
            a_spec <= (floatA[30:23] == 8'hFF);
            b_spec <= (floatB[30:23] == 8'hFF);
            cnt    <= 5'd24;
            busy   <= 1'b1;
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          // The remainder stays below 2*mB, so it always fits in 25 bits.
          if (!diff[25]) begin
            rem <= diff[24:0] << 1;
            q   <= {q[23:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[23:0], 1'b0};
          end
          if (cnt == 5'd0) begin
            state <= NORM;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        NORM: begin
          quotient    <= res_q;
          div_by_zero <= res_dbz;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
